alu_mutant_checker: RTL and testbench

Downstream response checker for the 4-bit ALU under test, golden or mutated. Each cycle it accepts one applied vector (A, B, opcode) together with the ALU's `result` and `zero_flag`, and recomputes the golden response. It flags any mismatch one cycle later and accumulates per-run kill statistics. A mutant counts as "killed" once any checked vector mismatches.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_golden_model.sv | 30 +++
 rtl/alu_mutant_checker.sv | 148 ++++++++++++++
 tb/tb_alu_mutant_checker.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU checkers: opcodes, data width and
// the kill-tracking state encoding.
package alu_pkg;

   localparam int ALU_W = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_EQ  = 3'b101;
   localparam logic [2:0] OP_LT  = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      KILLED = 2'd2
   } state_t;

endpackage

// File: rtl/alu_golden_model.sv
// Purely combinational reference ALU; all arithmetic is unsigned mod 2^ALU_W.
module alu_golden_model
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [2:0]       opcode,
   output logic [ALU_W-1:0] result,
   output logic             zero
);

   // Opcode decode to the reference result
   always_comb begin
      result = '0;
      case (opcode)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_EQ:   result = {{(ALU_W-1){1'b0}}, (a == b)};
         OP_LT:   result = {{(ALU_W-1){1'b0}}, (a < b)};
         OP_NOP:  result = '0;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_mutant_checker.sv
// Two-stage response checker for the ALU under test. Stage 1 registers each
// vector with its mismatch verdict; stage 2 reports the verdict for one cycle
// and folds it into the kill statistics and first-fail capture.
//
// Handshake: in_valid is a one-cycle qualifier with no back-pressure; every
// accepted vector yields exactly one out_valid pulse on the next cycle unless
// rst or clear is high in either of those two cycles, in which case the vector
// is dropped silently. mismatch is meaningful only while out_valid is high.
module alu_mutant_checker
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   input  logic [2:0]       opcode,
   input  logic [3:0]       dut_result,
   input  logic             dut_zero,
   output logic             out_valid,
   output logic             mismatch,
   output logic             killed,
   output logic [CNT_W-1:0] vector_count,
   output logic [CNT_W-1:0] mismatch_count,
   output logic [7:0]       op_fail_mask,
   output logic             ff_valid,
   output logic [3:0]       ff_a,
   output logic [3:0]       ff_b,
   output logic [2:0]       ff_opcode,
   output logic [3:0]       ff_result,
   output logic [1:0]       fsm_state
);

   logic             flush;
   logic [3:0]       gold_result;
   logic             gold_zero;
   logic             vec_mismatch;

   logic             s1_valid;
   logic             s1_mismatch;
   logic [3:0]       s1_a;
   logic [3:0]       s1_b;
   logic [2:0]       s1_op;
   logic [3:0]       s1_result;

   state_t           state_q;
   state_t           state_d;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // rst and clear have identical effect, including on a vector in flight
   assign flush = rst | clear;

   alu_golden_model u_golden (
      .a      (a),
      .b      (b),
      .opcode (opcode),
      .result (gold_result),
      .zero   (gold_zero)
   );

   assign vec_mismatch = (dut_result != gold_result) | (dut_zero != gold_zero);

   // Gating with flush suppresses the pulse for a vector discarded in stage 1
   assign out_valid = s1_valid & ~flush;
   assign mismatch  = out_valid & s1_mismatch;
   assign killed    = (state_q == KILLED);
   assign fsm_state = state_q;

   // Stage 1: capture the vector and its verdict
   always_ff @(posedge clk) begin
      if (flush) begin
         s1_valid    <= 1'b0;
         s1_mismatch <= 1'b0;
         s1_a        <= '0;
         s1_b        <= '0;
         s1_op       <= '0;
         s1_result   <= '0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_mismatch <= vec_mismatch;
            s1_a        <= a;
            s1_b        <= b;
            s1_op       <= opcode;
            s1_result   <= dut_result;
         end
      end
   end

   // Stage 2: saturating counters, per-opcode fail mask, first-fail capture
   always_ff @(posedge clk) begin
      if (flush) begin
         vector_count   <= '0;
         mismatch_count <= '0;
         op_fail_mask   <= '0;
         ff_valid       <= 1'b0;
         ff_a           <= '0;
         ff_b           <= '0;
         ff_opcode      <= '0;
         ff_result      <= '0;
      end else if (s1_valid) begin
         if (vector_count != CNT_MAX) begin
            vector_count <= vector_count + CNT_ONE;
         end
         if (s1_mismatch) begin
            if (mismatch_count != CNT_MAX) begin
               mismatch_count <= mismatch_count + CNT_ONE;
            end
            op_fail_mask[s1_op] <= 1'b1;
            if (!ff_valid) begin
               ff_valid  <= 1'b1;
               ff_a      <= s1_a;
               ff_b      <= s1_b;
               ff_opcode <= s1_op;
               ff_result <= s1_result;
            end
         end
      end
   end

   // Kill-tracking state register
   always_ff @(posedge clk) begin
      if (flush) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: first checked vector leaves IDLE, any mismatch is terminal
   always_comb begin
      state_d = state_q;
      if (out_valid) begin
         case (state_q)
            IDLE:    state_d = s1_mismatch ? KILLED : RUN;
            RUN:     state_d = s1_mismatch ? KILLED : RUN;
            KILLED:  state_d = KILLED;
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mutant_checker.sv
// Directed and randomised bench for alu_mutant_checker (CNT_W = 4 so that
// saturation is reachable quickly).
module tb_alu_mutant_checker;

  localparam int CW = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_KILLED = 2'd2;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          in_valid;
  logic [3:0]    a;
  logic [3:0]    b;
  logic [2:0]    opcode;
  logic [3:0]    dut_result;
  logic          dut_zero;
  logic          out_valid;
  logic          mismatch;
  logic          killed;
  logic [CW-1:0] vector_count;
  logic [CW-1:0] mismatch_count;
  logic [7:0]    op_fail_mask;
  logic          ff_valid;
  logic [3:0]    ff_a;
  logic [3:0]    ff_b;
  logic [2:0]    ff_opcode;
  logic [3:0]    ff_result;
  logic [1:0]    fsm_state;

  logic [0:0] exp_q[$];
  int n_vec;
  int n_checks;
  int errors;

  alu_mutant_checker #(.CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .clear          (clear),
    .in_valid       (in_valid),
    .a              (a),
    .b              (b),
    .opcode         (opcode),
    .dut_result     (dut_result),
    .dut_zero       (dut_zero),
    .out_valid      (out_valid),
    .mismatch       (mismatch),
    .killed         (killed),
    .vector_count   (vector_count),
    .mismatch_count (mismatch_count),
    .op_fail_mask   (op_fail_mask),
    .ff_valid       (ff_valid),
    .ff_a           (ff_a),
    .ff_b           (ff_b),
    .ff_opcode      (ff_opcode),
    .ff_result      (ff_result),
    .fsm_state      (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_alu(input logic [3:0] x, input logic [3:0] y,
                                         input logic [2:0] op);
    logic [4:0] t;
    case (op)
      3'd0: t = {1'b0, x} + {1'b0, y};
      3'd1: t = {1'b0, x} + {1'b0, ~y} + 5'd1;
      3'd2: t = {1'b0, x & y};
      3'd3: t = {1'b0, x | y};
      3'd4: t = {1'b0, x ^ y};
      3'd5: t = (x == y) ? 5'd1 : 5'd0;
      3'd6: t = (x < y) ? 5'd1 : 5'd0;
      default: t = 5'd0;
    endcase
    return t[3:0];
  endfunction

  function automatic logic ref_miss(input logic [3:0] x, input logic [3:0] y,
                                    input logic [2:0] op, input logic [3:0] r,
                                    input logic z);
    logic [3:0] g;
    g = ref_alu(x, y, op);
    return (r != g) || (z != (g == 4'd0));
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
      $error("check %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [0:0] e;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_mismatch", {31'd0, mismatch}, {31'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_vec(input logic [3:0] x, input logic [3:0] y, input logic [2:0] op,
                           input logic [3:0] r, input logic z);
    a = x;
    b = y;
    opcode = op;
    dut_result = r;
    dut_zero = z;
    in_valid = 1'b1;
    exp_q.push_back(ref_miss(x, y, op, r, z));
    n_vec++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_killed"}, {31'd0, killed}, 32'd0);
    check({tag, "_vcount"}, 32'(vector_count), 32'd0);
    check({tag, "_mcount"}, 32'(mismatch_count), 32'd0);
    check({tag, "_mask"}, 32'(op_fail_mask), 32'd0);
    check({tag, "_ff_valid"}, {31'd0, ff_valid}, 32'd0);
    check({tag, "_ff_fields"}, {17'd0, ff_a, ff_b, ff_opcode, ff_result}, 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(S_IDLE));
  endtask

  task automatic check_ff(input string tag, input logic [3:0] x, input logic [3:0] y,
                          input logic [2:0] op, input logic [3:0] r);
    check({tag, "_ff_valid"}, {31'd0, ff_valid}, 32'd1);
    check({tag, "_ff_fields"}, {17'd0, ff_a, ff_b, ff_opcode, ff_result},
          {17'd0, x, y, op, r});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e_vec;
    int e_mm;
    logic [7:0] e_mask;
    logic e_ffv;
    logic [14:0] e_ff;
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] op;
    logic [3:0] r;
    logic z;

    n_vec = 0;
    n_checks = 0;
    errors = 0;
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    opcode = '0;
    dut_result = '0;
    dut_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("reset");

    // ADD mutant: 3+5 reported as 10
    apply_vec(4'd3, 4'd5, 3'b000, 4'd10, 1'b0);
    check("add_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_mismatch", {31'd0, mismatch}, 32'd1);
    idle(1);
    check("add_killed", {31'd0, killed}, 32'd1);
    check("add_state", 32'(fsm_state), 32'(S_KILLED));
    check("add_vcount", 32'(vector_count), 32'd1);
    check("add_mcount", 32'(mismatch_count), 32'd1);
    check("add_mask", 32'(op_fail_mask), 32'h01);
    check_ff("add", 4'd3, 4'd5, 3'b000, 4'd10);

    // Masking vector keeps RUN; later failures do not overwrite first capture
    do_reset();
    apply_vec(4'd2, 4'd3, 3'b000, 4'd5, 1'b0);
    apply_vec(4'd5, 4'd5, 3'b000, 4'd10, 1'b0);
    check("mask_mismatch", {31'd0, mismatch}, 32'd0);
    idle(1);
    check("mask_state_run", 32'(fsm_state), 32'(S_RUN));
    check("mask_killed", {31'd0, killed}, 32'd0);
    check("mask_ff_valid", {31'd0, ff_valid}, 32'd0);
    apply_vec(4'd1, 4'd2, 3'b000, 4'd4, 1'b0);
    apply_vec(4'd7, 4'd1, 3'b001, 4'd9, 1'b0);
    idle(1);
    check("mask_state_killed", 32'(fsm_state), 32'(S_KILLED));
    check("mask_vcount", 32'(vector_count), 32'd4);
    check("mask_mcount", 32'(mismatch_count), 32'd2);
    check("mask_opmask", 32'(op_fail_mask), 32'h03);
    check_ff("mask", 4'd1, 4'd2, 3'b000, 4'd4);

    // Zero-flag-only error: A & 5 = 0, DUT result right but zero flag low
    do_reset();
    apply_vec(4'hA, 4'h5, 3'b010, 4'd0, 1'b0);
    check("zflag_mismatch", {31'd0, mismatch}, 32'd1);
    idle(1);
    check("zflag_mcount", 32'(mismatch_count), 32'd1);
    check("zflag_opmask", 32'(op_fail_mask), 32'h04);
    check_ff("zflag", 4'hA, 4'h5, 3'b010, 4'd0);

    // Random back-to-back vectors over all opcodes, some corrupted
    do_reset();
    e_vec = 0;
    e_mm = 0;
    e_mask = '0;
    e_ffv = 1'b0;
    e_ff = '0;
    for (int i = 0; i < 24; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      op = 3'($urandom_range(0, 7));
      r = ref_alu(x, y, op);
      z = (r == 4'd0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) r = r ^ 4'($urandom_range(1, 15));
        else z = ~z;
      end
      e_vec = sat_inc(e_vec);
      if (ref_miss(x, y, op, r, z)) begin
        e_mm = sat_inc(e_mm);
        e_mask[op] = 1'b1;
        if (!e_ffv) begin
          e_ffv = 1'b1;
          e_ff = {x, y, op, r};
        end
      end
      apply_vec(x, y, op, r, z);
    end
    idle(1);
    check("rand_vcount", 32'(vector_count), 32'(e_vec));
    check("rand_mcount", 32'(mismatch_count), 32'(e_mm));
    check("rand_opmask", 32'(op_fail_mask), 32'(e_mask));
    check("rand_killed", {31'd0, killed}, {31'd0, e_ffv});
    check("rand_ff_valid", {31'd0, ff_valid}, {31'd0, e_ffv});
    check("rand_ff_fields", {17'd0, ff_a, ff_b, ff_opcode, ff_result}, {17'd0, e_ff});

    // Saturation: 20 mismatching vectors into 4-bit counters
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply_vec(4'(i), 4'd0, 3'b111, 4'd1, 1'b0);
    end
    idle(1);
    check("sat_vcount", 32'(vector_count), 32'd15);
    check("sat_mcount", 32'(mismatch_count), 32'd15);
    check("sat_opmask", 32'(op_fail_mask), 32'h80);
    check_ff("sat", 4'd0, 4'd0, 3'b111, 4'd1);

    // Clear colliding with a mismatching vector: clear wins
    do_reset();
    apply_vec(4'd9, 4'd9, 3'b101, 4'd0, 1'b1);
    idle(1);
    check("pre_clear_vcount", 32'(vector_count), 32'd1);
    clear = 1'b1;
    a = 4'd3;
    b = 4'd5;
    opcode = 3'b000;
    dut_result = 4'd10;
    dut_zero = 1'b0;
    in_valid = 1'b1;
    n_vec++;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    check_cleared("clear");
    idle(2);
    check("clear_after_vcount", 32'(vector_count), 32'd0);

    // Reset while a vector sits in stage 1
    apply_vec(4'd2, 4'd2, 3'b001, 4'd3, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("rstmid_out_valid_n1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("rstmid");
    idle(2);
    check_cleared("rstmid_later");

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, errors);
    $finish;
  end

endmodule
